// File: rtl/qwi_axis2vid.sv
// ---------------------------------------------------------------------------
// qwi_axis2vid : AXI-Stream to native video bridge, frame-locked to a VTG.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qwi_axis2vid #(
  parameter int DATA_WID   = 24,
  parameter int FIFO_DEPTH = 32,
  parameter int FILL_LEVEL = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_WID-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tuser,
  input  logic                s_tlast,
  input  logic                t_hsync,
  input  logic                t_vsync,
  input  logic                t_active,
  input  logic                t_hblank,
  input  logic                t_vblank,
  output logic                vtg_ce,
  output logic [DATA_WID-1:0] vid_data,
  output logic                vid_hsync,
  output logic                vid_vsync,
  output logic                vid_active,
  output logic                vid_hblank,
  output logic                vid_vblank,
  output logic                locked,
  output logic                underflow
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] FILL_LVL = (AW+1)'(FILL_LEVEL);

  typedef enum logic [1:0] {
    WAIT_SOF   = 2'd0,
    WAIT_FILL  = 2'd1,
    WAIT_FRAME = 2'd2,
    LOCKED     = 2'd3
  } state_t;

  state_t              state_q;
  logic [DATA_WID:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_q;
  logic [AW:0]         rd_ptr_q;
  logic                vb_q;
  logic [DATA_WID-1:0] vid_data_q;
  logic [4:0]          timing_q;
  logic                underflow_q;

  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              flush;
  logic              underflow_d;
  logic              resync;
  logic [DATA_WID:0] head;
  logic              unused_tlast;

  assign unused_tlast = s_tlast;

  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == DEPTH);
  assign empty  = (count == '0);
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  assign s_tready = rst_n && ((state_q == WAIT_SOF) || !full);
  assign accept   = s_tvalid && s_tready;

  // vb_q marks that the next active pixel is the first one after vblank,
  // which is the only place an SOF-tagged entry may legally be popped.
  always_comb begin
    pop         = 1'b0;
    underflow_d = 1'b0;
    resync      = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        if (vb_q && t_active && !empty) begin
          pop    = 1'b1;
          resync = !head[DATA_WID];
        end
      end
      LOCKED: begin
        if (t_active) begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            pop    = 1'b1;
            resync = head[DATA_WID] && !vb_q;
          end
        end
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  // A flush discards anything accepted on the same cycle.
  assign flush = underflow_d || resync;
  assign push  = accept && ((state_q != WAIT_SOF) || s_tuser) && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= WAIT_SOF;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vb_q     <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      if ((state_q == WAIT_FRAME) || (state_q == LOCKED)) begin
        if (t_vblank)      vb_q <= 1'b1;
        else if (t_active) vb_q <= 1'b0;
      end else begin
        vb_q <= 1'b0;
      end

      case (state_q)
        WAIT_SOF:   if (accept && s_tuser) state_q <= WAIT_FILL;
        WAIT_FILL:  if (count >= FILL_LVL) state_q <= WAIT_FRAME;
        WAIT_FRAME: if (pop) state_q <= resync ? WAIT_SOF : LOCKED;
        LOCKED:     if (flush) state_q <= WAIT_SOF;
        default:    state_q <= WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_tuser, s_tdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vid_data_q  <= '0;
      timing_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      vid_data_q  <= pop ? head[DATA_WID-1:0] : '0;
      timing_q    <= {t_hsync, t_vsync, t_active, t_hblank, t_vblank};
      underflow_q <= underflow_d;
    end
  end

  assign vid_data   = vid_data_q;
  assign vid_hsync  = timing_q[4];
  assign vid_vsync  = timing_q[3];
  assign vid_active = timing_q[2];
  assign vid_hblank = timing_q[1];
  assign vid_vblank = timing_q[0];
  assign underflow  = underflow_q;
  assign locked     = (state_q == LOCKED);
  assign vtg_ce     = (state_q == WAIT_FRAME) || (state_q == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_qwi_axis2vid.sv
// ---------------------------------------------------------------------------
// tb_qwi_axis2vid : scoreboard bench for the AXI-Stream to video bridge.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_qwi_axis2vid;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tuser = 1'b0;
  logic          s_tlast = 1'b0;
  logic          t_hsync = 1'b0, t_vsync = 1'b0, t_active = 1'b0;
  logic          t_hblank = 1'b0, t_vblank = 1'b0;
  logic          vtg_ce;
  logic [DW-1:0] vid_data;
  logic          vid_hsync, vid_vsync, vid_active, vid_hblank, vid_vblank;
  logic          locked, underflow;

  qwi_axis2vid #(.DATA_WID(DW), .FIFO_DEPTH(32), .FILL_LEVEL(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .t_hsync(t_hsync), .t_vsync(t_vsync), .t_active(t_active),
    .t_hblank(t_hblank), .t_vblank(t_vblank),
    .vtg_ce(vtg_ce), .vid_data(vid_data),
    .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_active(vid_active),
    .vid_hblank(vid_hblank), .vid_vblank(vid_vblank),
    .locked(locked), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] next_pix = '0;
  bit            sb_en = 1'b0;
  logic          last_acc;
  logic [4:0]    prev_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; outputs are observed 1 time unit after the edge.
  task automatic drive(input logic act, vb, hb, hs, vs, valid, user);
    t_active = act; t_vblank = vb; t_hblank = hb; t_hsync = hs; t_vsync = vs;
    s_tvalid = valid; s_tuser = user; s_tdata = next_pix;
    #1;
    last_acc = valid && s_tready;
    prev_t   = {hs, vs, act, hb, vb};
    tick();
    if (last_acc) begin
      if (sb_en) exp_q.push_back(next_pix);
      next_pix = next_pix + 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 1);
    drive(1, 1, 1, 1, 1, 1, 1);
    total++;
    if ({locked, underflow, vtg_ce, vid_hsync, vid_vsync, vid_active, vid_hblank, vid_vblank} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000000",
               {locked, underflow, vtg_ce, vid_hsync, vid_vsync, vid_active, vid_hblank, vid_vblank});
    end
    total++;
    if (vid_data !== '0) begin bad++; $display("FAIL reset_vid_data got=%h want=0", vid_data); end
    total++;
    if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", s_tready); end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_drop_nonsof();
    int acc;
    acc = 0;
    sb_en = 1'b0;
    next_pix = 24'h000AA0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      if (last_acc) acc++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (acc !== 4) begin bad++; $display("FAIL drop_accepted got=%0d want=4", acc); end
    total++;
    if ({vtg_ce, locked} !== 2'b00) begin bad++; $display("FAIL drop_state got=%b want=00", {vtg_ce, locked}); end
  endtask

  task automatic test_fill();
    int acc;
    acc = 0;
    sb_en = 1'b1;
    next_pix = 24'h000001;
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 0, 0, 0, 1, (i == 0));
      if (last_acc) acc++;
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (acc !== 15) begin bad++; $display("FAIL fill_accepted got=%0d want=15", acc); end
    total++;
    if (vtg_ce !== 1'b0) begin bad++; $display("FAIL fill_vtg_ce_15 got=%b want=0", vtg_ce); end
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({vtg_ce, locked} !== 2'b10) begin bad++; $display("FAIL fill_vtg_ce_16 got=%b want=10", {vtg_ce, locked}); end
  endtask

  task automatic test_lock();
    int j;
    logic act;
    logic [DW-1:0] e;
    for (int i = 0; i < 51; i++) begin
      if (i < 3) begin
        drive(0, 1, 0, 0, (i == 0), 1, 0);
      end else begin
        j = (i - 3) % 12;
        act = (j < 8);
        drive(act, 0, !act, (j == 9 || j == 10), 0, 1, 0);
      end
      total++;
      if ({vid_hsync, vid_vsync, vid_active, vid_hblank, vid_vblank} !== prev_t) begin
        bad++;
        $display("FAIL lock_timing cyc=%0d got=%b want=%b", i,
                 {vid_hsync, vid_vsync, vid_active, vid_hblank, vid_vblank}, prev_t);
      end
      e = '0;
      if (prev_t[2]) begin
        if (exp_q.size() == 0) begin bad++; $display("FAIL lock_sb_empty cyc=%0d got=%h want=none", i, vid_data); end
        else e = exp_q.pop_front();
      end
      total++;
      if (vid_data !== e) begin bad++; $display("FAIL lock_data cyc=%0d got=%h want=%h", i, vid_data, e); end
      total++;
      if (underflow !== 1'b0) begin bad++; $display("FAIL lock_underflow cyc=%0d got=%b want=0", i, underflow); end
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked got=%b want=1", locked); end
  endtask

  task automatic test_underflow();
    int j;
    bit got_uf;
    logic act;
    logic [DW-1:0] e;
    got_uf = 1'b0;
    for (int i = 0; i < 240; i++) begin
      j = i % 12;
      act = (j < 8);
      drive(act, 0, !act, 0, 0, 0, 0);
      if (act && exp_q.size() == 0) begin
        total++;
        if ({underflow, locked, vtg_ce} !== 3'b100 || vid_data !== '0) begin
          bad++;
          $display("FAIL uf_event got uf/lk/ce=%b data=%h want 100 data=0", {underflow, locked, vtg_ce}, vid_data);
        end
        got_uf = 1'b1;
        break;
      end
      e = act ? exp_q.pop_front() : '0;
      total++;
      if (vid_data !== e || underflow !== 1'b0) begin
        bad++;
        $display("FAIL uf_drain cyc=%0d got data=%h uf=%b want data=%h uf=0", i, vid_data, underflow, e);
      end
    end
    total++;
    if (!got_uf) begin bad++; $display("FAIL uf_timeout got=none want=underflow"); end
    drive(1, 0, 0, 0, 0, 0, 0);
    total++;
    if ({underflow, locked, vid_data} !== '0) begin
      bad++;
      $display("FAIL uf_single_pulse got uf=%b lk=%b data=%h want 0 0 0", underflow, locked, vid_data);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    logic [DW-1:0] e;
    acc = 0;
    exp_q.delete();
    next_pix = 24'h000100;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 0, 0, 1, (i == 0));
      if (last_acc) acc++;
    end
    total++;
    if (acc !== 32) begin bad++; $display("FAIL bp_accepted got=%0d want=32", acc); end
    total++;
    if (s_tready !== 1'b0) begin bad++; $display("FAIL bp_tready_full got=%b want=0", s_tready); end
    drive(0, 1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    total++;
    if ({s_tready, locked} !== 2'b11) begin bad++; $display("FAIL bp_tready_after_pop got=%b want=11", {s_tready, locked}); end
    total++;
    if (vid_data !== e) begin bad++; $display("FAIL bp_first_pixel got=%h want=%h", vid_data, e); end
  endtask

  task automatic test_resync();
    int acc;
    bit hit;
    logic [DW-1:0] e;
    logic [DW-1:0] sof_pix;
    acc = 0;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (vid_data !== e || locked !== 1'b1) begin
        bad++;
        $display("FAIL rs_pre_data got=%h lk=%b want=%h lk=1", vid_data, locked, e);
      end
    end
    sof_pix = next_pix;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, 0, 1, (i == 0));
      if (last_acc) acc++;
    end
    total++;
    if (acc !== 6) begin bad++; $display("FAIL rs_inject_accepted got=%0d want=6", acc); end
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      total++;
      if (vid_data !== e) begin bad++; $display("FAIL rs_data cyc=%0d got=%h want=%h", i, vid_data, e); end
      if (e == sof_pix) begin
        total++;
        if ({locked, underflow} !== 2'b00) begin
          bad++;
          $display("FAIL rs_event got lk/uf=%b want=00", {locked, underflow});
        end
        exp_q.delete();
        hit = 1'b1;
        break;
      end
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL rs_locked cyc=%0d got=%b want=1", i, locked); end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rs_timeout got=none want=resync"); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      total++;
      if ({locked, underflow, vid_data} !== '0) begin
        bad++;
        $display("FAIL rs_post got lk=%b uf=%b data=%h want 0 0 0", locked, underflow, vid_data);
      end
    end
    // Refill from scratch: if the leftovers survived, WAIT_FRAME comes early.
    next_pix = 24'h000200;
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 0, 0, 1, (i == 0));
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (vtg_ce !== 1'b0) begin bad++; $display("FAIL rs_flushed got vtg_ce=%b want=0", vtg_ce); end
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (vtg_ce !== 1'b1) begin bad++; $display("FAIL rs_refill got vtg_ce=%b want=1", vtg_ce); end
  endtask

  task automatic test_reset_midline();
    logic [DW-1:0] e;
    drive(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (vid_data !== e || locked !== 1'b1) begin
        bad++;
        $display("FAIL mr_data got=%h lk=%b want=%h lk=1", vid_data, locked, e);
      end
    end
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 0);
    total++;
    if ({locked, underflow, vtg_ce, vid_hsync, vid_vsync, vid_active, vid_hblank, vid_vblank, s_tready} !== 9'h000
        || vid_data !== '0) begin
      bad++;
      $display("FAIL mr_outputs got=%b data=%h want=000000000 data=0",
               {locked, underflow, vtg_ce, vid_hsync, vid_vsync, vid_active, vid_hblank, vid_vblank, s_tready},
               vid_data);
    end
    exp_q.delete();
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      total++;
      if ({locked, vtg_ce, vid_active} !== 3'b001 || vid_data !== '0) begin
        bad++;
        $display("FAIL mr_no_pop got lk/ce/act=%b data=%h want 001 data=0", {locked, vtg_ce, vid_active}, vid_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_drop_nonsof();
    test_fill();
    test_lock();
    test_underflow();
    test_back_to_back();
    test_resync();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
